biu_bus_arbiter: RTL and testbench
==================================

// Module: biu_bus_arbiter
// PURPOSE
//  Arbitrates the shared bus interface unit between the fetch control unit (instruction
//  prefetch) and the execution unit (operand load/store). Latches the winner's op/address,
//  issues a one-cycle cs_biu strobe, waits for ready_bus, and returns done or timeout to the
//  winner. Sits between fcu/eu and biu; replaces direct cs_biu/sel_biu driving by both units.
// PARAMETERS
//  ADDR_W        16  address width forwarded to biu
//  TIMEOUT       15  WAIT-state cycles without ready_bus before transaction aborts (>=2)
//  STARVE_LIMIT  4   consecutive EU wins while FCU requests before FCU is forced to win (>=1)
// PORTS
//  clk           in   1       clock, all logic on rising edge
//  reset         in   1       synchronous, active-high reset
//  req_fcu       in   1       fetch unit requests bus; held until done_fcu
//  op_fcu        in   2       fetch unit bus op (sel_biu encoding)
//  addr_fcu      in   ADDR_W  fetch address
//  req_eu        in   1       execution unit requests bus; held until done_eu
//  op_eu         in   2       execution unit bus op
//  addr_eu       in   ADDR_W  execution unit address
//  ready_bus     in   1       biu completion, sampled only in WAIT
//  cs_biu        out  1       one-cycle biu start strobe
//  sel_biu       out  2       latched op of current owner
//  addr_biu      out  ADDR_W  latched address of current owner
//  grant_fcu     out  1       fcu owns bus (ISSUE..DONE)
//  grant_eu      out  1       eu owns bus (ISSUE..DONE)
//  done_fcu      out  1       one-cycle completion pulse to fcu
//  done_eu       out  1       one-cycle completion pulse to eu
//  timeout_err   out  1       asserted with done_* when transaction timed out
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; sel_biu/addr_biu=0; timer=0; starve_cnt=0.
//  States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE (all registered, Moore outputs).
//  IDLE: no req -> stay. Any req -> latch winner, its op/addr into sel_biu/addr_biu; go ISSUE.
//   Priority: EU > FCU, except when both request and starve_cnt==STARVE_LIMIT -> FCU wins.
//   starve_cnt: +1 on EU win with req_fcu high; cleared on any FCU win; saturates at limit.
//  ISSUE: cs_biu=1 exactly this cycle; grant_<winner>=1; timer cleared; ready_bus ignored; go WAIT.
//  WAIT: ready_bus=1 -> DONE, err=0. Else timer+1; timer==TIMEOUT-1 and no ready -> DONE, err=1.
//   ready_bus on the same cycle as timeout expiry: ready wins, err=0.
//  DONE: done_<winner>=1 one cycle, timeout_err=err; grant held; go IDLE; grant drops in IDLE.
//  sel_biu/addr_biu stable ISSUE..DONE; hold last value in IDLE until next latch.
//  Latency: req seen in IDLE cycle n -> cs_biu n+1 -> earliest ready n+2 -> done n+3.
//  Min 4 cycles per transaction; held req re-arbitrates in next IDLE (no back-to-back skip).
//  Requester dropping req mid-transaction: ignored, transaction completes, done still pulses.
//  Op/addr changes after latch: ignored. grant_fcu and grant_eu never both 1.
//  Reset mid-transaction: IDLE next edge, all outputs 0, no done pulse, pending op lost.
//  cs_biu never asserted outside ISSUE; no second strobe on timeout.
// TESTING
//  Single FCU req op=2'b01 addr=16'h0040, ready_bus at WAIT+2 -> cs_biu 1 cycle, addr_biu=0040, done_fcu 1 cycle, err=0.
//  req_fcu & req_eu together from reset -> EU granted first; FCU granted in next arbitration.
//  EU+FCU held continuously, STARVE_LIMIT=4 -> grant order EU,EU,EU,EU,FCU,EU...; starve_cnt clears.
//  No ready_bus, TIMEOUT=15 -> done_eu with timeout_err=1 after 15 WAIT cycles; next req runs normally.
//  ready_bus asserted exactly on timeout cycle -> done with timeout_err=0.
//  reset pulsed during WAIT -> next cycle all outputs 0, state IDLE, no done pulse; fresh req accepted.

Source files
------------

// File: rtl/biu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// biu_bus_arbiter
//
// Shares the bus interface unit between the fetch control unit (instruction
// prefetch) and the execution unit (operand load/store). The arbiter picks a
// winner, latches that unit's op and address, and issues a single-cycle
// cs_biu strobe. It then waits for ready_bus and returns a done pulse to the
// winner. If the bus does not answer in time, the done pulse carries
// timeout_err.
//
// Handshake: a requester raises req_* and holds it, with op/addr stable, until
// its done_* pulse. The op/addr are captured only on the arbitration cycle.
// Later changes, and a request dropped mid-transaction, are ignored: the
// transaction still completes and done_* still pulses. ready_bus is only
// looked at while waiting. Every transaction runs IDLE -> ISSUE -> WAIT ->
// DONE -> IDLE, so it takes at least four cycles. A request that is still
// held is re-arbitrated in the following IDLE cycle.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req/op/addr_fcu       fetch unit request, bus op, address
//   req/op/addr_eu        execution unit request, bus op, address
//   ready_bus             biu completion
//   cs_biu                one-cycle biu start strobe
//   sel_biu, addr_biu     latched op/address of the current owner
//   grant_fcu, grant_eu   ownership, ISSUE through DONE
//   done_fcu, done_eu     one-cycle completion pulses
//   timeout_err           qualifies done_* when the transaction timed out
// ---------------------------------------------------------------------------
module biu_bus_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int TIMEOUT      = 15,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_fcu,
   input  logic [1:0]        op_fcu,
   input  logic [ADDR_W-1:0] addr_fcu,
   input  logic              req_eu,
   input  logic [1:0]        op_eu,
   input  logic [ADDR_W-1:0] addr_eu,
   input  logic              ready_bus,
   output logic              cs_biu,
   output logic [1:0]        sel_biu,
   output logic [ADDR_W-1:0] addr_biu,
   output logic              grant_fcu,
   output logic              grant_eu,
   output logic              done_fcu,
   output logic              done_eu,
   output logic              timeout_err
);

   // The timer only counts up to TIMEOUT-1. The starve counter saturates at
   // STARVE_LIMIT.
   localparam int TMR_W = $clog2(TIMEOUT);
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [STV_W-1:0]    starve_q, starve_d;
   logic                cs_q, cs_d;
   logic [1:0]          sel_q, sel_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                grant_fcu_q, grant_fcu_d;
   logic                grant_eu_q, grant_eu_d;
   logic                done_fcu_q, done_fcu_d;
   logic                done_eu_q, done_eu_d;
   logic                err_q, err_d;
   logic                fcu_wins;
   logic                starved;

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      starve_d    = starve_q;
      sel_d       = sel_q;
      addr_d      = addr_q;
      grant_fcu_d = grant_fcu_q;
      grant_eu_d  = grant_eu_q;
      cs_d        = 1'b0;
      done_fcu_d  = 1'b0;
      done_eu_d   = 1'b0;
      err_d       = 1'b0;
      starved     = (starve_q == STV_W'(STARVE_LIMIT));
      // EU normally has priority. FCU wins only when it is alone, or when it
      // has lost STARVE_LIMIT contested rounds in a row.
      fcu_wins    = req_fcu && (!req_eu || starved);

      case (state_q)
         S_IDLE: begin
            if (req_fcu || req_eu) begin
               state_d = S_ISSUE;
               cs_d    = 1'b1;
               if (fcu_wins) begin
                  grant_fcu_d = 1'b1;
                  sel_d       = op_fcu;
                  addr_d      = addr_fcu;
                  starve_d    = '0;
               end else begin
                  grant_eu_d = 1'b1;
                  sel_d      = op_eu;
                  addr_d     = addr_eu;
                  if (req_fcu && !starved) begin
                     starve_d = starve_q + STV_W'(1);
                  end
               end
            end
         end
         S_ISSUE: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // ready_bus takes precedence over expiry in the same cycle.
            if (ready_bus) begin
               state_d    = S_DONE;
               done_fcu_d = grant_fcu_q;
               done_eu_d  = grant_eu_q;
            end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
               state_d    = S_DONE;
               done_fcu_d = grant_fcu_q;
               done_eu_d  = grant_eu_q;
               err_d      = 1'b1;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         S_DONE: begin
            state_d     = S_IDLE;
            grant_fcu_d = 1'b0;
            grant_eu_d  = 1'b0;
         end
         default: begin
            state_d     = S_IDLE;
            grant_fcu_d = 1'b0;
            grant_eu_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         timer_q     <= '0;
         starve_q    <= '0;
         cs_q        <= 1'b0;
         sel_q       <= '0;
         addr_q      <= '0;
         grant_fcu_q <= 1'b0;
         grant_eu_q  <= 1'b0;
         done_fcu_q  <= 1'b0;
         done_eu_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         starve_q    <= starve_d;
         cs_q        <= cs_d;
         sel_q       <= sel_d;
         addr_q      <= addr_d;
         grant_fcu_q <= grant_fcu_d;
         grant_eu_q  <= grant_eu_d;
         done_fcu_q  <= done_fcu_d;
         done_eu_q   <= done_eu_d;
         err_q       <= err_d;
      end
   end

   assign cs_biu      = cs_q;
   assign sel_biu     = sel_q;
   assign addr_biu    = addr_q;
   assign grant_fcu   = grant_fcu_q;
   assign grant_eu    = grant_eu_q;
   assign done_fcu    = done_fcu_q;
   assign done_eu     = done_eu_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_biu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_biu_bus_arbiter
// Bench for biu_bus_arbiter. It runs a table of directed vectors, then
// hand-written corner sequences, then randomized traffic. Every cycle is
// also compared against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_biu_bus_arbiter;
   localparam int ADDR_W       = 16;
   localparam int TIMEOUT      = 15;
   localparam int STARVE_LIMIT = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_fcu, req_eu, ready_bus;
   logic [1:0]        op_fcu, op_eu;
   logic [ADDR_W-1:0] addr_fcu, addr_eu;
   logic              cs_biu, grant_fcu, grant_eu, done_fcu, done_eu, timeout_err;
   logic [1:0]        sel_biu;
   logic [ADDR_W-1:0] addr_biu;

   int checks = 0;
   int errors = 0;

   biu_bus_arbiter #(
      .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .reset(reset),
      .req_fcu(req_fcu), .op_fcu(op_fcu), .addr_fcu(addr_fcu),
      .req_eu(req_eu), .op_eu(op_eu), .addr_eu(addr_eu),
      .ready_bus(ready_bus),
      .cs_biu(cs_biu), .sel_biu(sel_biu), .addr_biu(addr_biu),
      .grant_fcu(grant_fcu), .grant_eu(grant_eu),
      .done_fcu(done_fcu), .done_eu(done_eu), .timeout_err(timeout_err)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // A transaction is tracked by phase: 0 idle, 1 strobe cycle, 2 waiting,
   // 3 completion cycle. It also tracks how many waiting cycles passed
   // without ready and how many contested rounds FCU has lost in a row.
   int                m_phase, m_waited, m_starve;
   logic              e_cs, e_gf, e_ge, e_df, e_de, e_err;
   logic [1:0]        e_sel;
   logic [ADDR_W-1:0] e_addr;

   task automatic model_finish(input logic err);
      e_df    = e_gf;
      e_de    = e_ge;
      e_err   = err;
      m_phase = 3;
   endtask

   // Apply one rising edge to the model using the inputs currently driven.
   task automatic model_edge();
      logic fcu;
      if (reset) begin
         {e_cs, e_gf, e_ge, e_df, e_de, e_err} = '0;
         e_sel = '0; e_addr = '0;
         m_phase = 0; m_waited = 0; m_starve = 0;
      end else begin
         e_cs = 0; e_df = 0; e_de = 0; e_err = 0;
         case (m_phase)
            0: if (req_fcu || req_eu) begin
               fcu = req_fcu && (!req_eu || m_starve == STARVE_LIMIT);
               if (fcu) begin
                  m_starve = 0; e_gf = 1; e_sel = op_fcu; e_addr = addr_fcu;
               end else begin
                  if (req_fcu) m_starve = (m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1;
                  e_ge = 1; e_sel = op_eu; e_addr = addr_eu;
               end
               e_cs = 1; m_phase = 1;
            end
            1: begin m_waited = 0; m_phase = 2; end
            2: if (ready_bus) model_finish(1'b0);
               else begin
                  m_waited++;
                  if (m_waited == TIMEOUT) model_finish(1'b1);
               end
            default: begin e_gf = 0; e_ge = 0; m_phase = 0; end
         endcase
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: update the model, take the edge, sample at the falling edge.
   task automatic step();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      chk("m_cs_biu", cs_biu, e_cs);
      chk("m_grant_fcu", grant_fcu, e_gf);
      chk("m_grant_eu", grant_eu, e_ge);
      chk("m_done_fcu", done_fcu, e_df);
      chk("m_done_eu", done_eu, e_de);
      chk("m_timeout_err", timeout_err, e_err);
      chk("m_sel_biu", sel_biu, e_sel);
      chk("m_addr_biu", addr_biu, e_addr);
      chk("grant_excl", grant_fcu & grant_eu, 0);
   endtask

   task automatic idle_inputs();
      reset = 0; req_fcu = 0; req_eu = 0; ready_bus = 0;
      op_fcu = 0; op_eu = 0; addr_fcu = 0; addr_eu = 0;
   endtask

   task automatic do_reset();
      reset = 1; step(); reset = 0;
   endtask

   // Step until cs_biu appears. A missing strobe within the budget counts as
   // a failed comparison.
   task automatic wait_cs(input string name);
      logic seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step();
         seen = cs_biu;
      end
      chk(name, seen, 1);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic rst, rf; logic [1:0] opf; logic [15:0] af;
      logic re;      logic [1:0] ope; logic [15:0] ae;
      logic rdy;
      logic cs, gf, ge, df, de, err; logic [1:0] sel; logic [15:0] addr;
   } vec_t;

   vec_t vt[14];
   logic [0:0] exp_q[$];
   logic [0:0] got_q[$];

   initial begin
      //         rst rf opf    af        re ope    ae        rdy  cs gf ge df de er sel    addr
      vt[0]  = '{1, 0, 2'b00, 16'h0000, 0, 2'b00, 16'h0000, 0,   0, 0, 0, 0, 0, 0, 2'b00, 16'h0000};
      vt[1]  = '{0, 1, 2'b01, 16'h0040, 0, 2'b00, 16'h0000, 0,   1, 1, 0, 0, 0, 0, 2'b01, 16'h0040};
      vt[2]  = '{0, 1, 2'b01, 16'h0040, 0, 2'b00, 16'h0000, 0,   0, 1, 0, 0, 0, 0, 2'b01, 16'h0040};
      vt[3]  = '{0, 1, 2'b01, 16'h0040, 0, 2'b00, 16'h0000, 0,   0, 1, 0, 0, 0, 0, 2'b01, 16'h0040};
      vt[4]  = '{0, 1, 2'b01, 16'h0040, 0, 2'b00, 16'h0000, 1,   0, 1, 0, 1, 0, 0, 2'b01, 16'h0040};
      vt[5]  = '{0, 0, 2'b00, 16'h0000, 0, 2'b00, 16'h0000, 0,   0, 0, 0, 0, 0, 0, 2'b01, 16'h0040};
      vt[6]  = '{0, 1, 2'b10, 16'h1234, 1, 2'b11, 16'hABCD, 0,   1, 0, 1, 0, 0, 0, 2'b11, 16'hABCD};
      vt[7]  = '{0, 1, 2'b10, 16'h1234, 1, 2'b00, 16'hFFFF, 0,   0, 0, 1, 0, 0, 0, 2'b11, 16'hABCD};
      vt[8]  = '{0, 1, 2'b10, 16'h1234, 0, 2'b00, 16'h0000, 1,   0, 0, 1, 0, 1, 0, 2'b11, 16'hABCD};
      vt[9]  = '{0, 1, 2'b10, 16'h1234, 0, 2'b00, 16'h0000, 0,   0, 0, 0, 0, 0, 0, 2'b11, 16'hABCD};
      vt[10] = '{0, 1, 2'b10, 16'h1234, 0, 2'b00, 16'h0000, 0,   1, 1, 0, 0, 0, 0, 2'b10, 16'h1234};
      vt[11] = '{0, 1, 2'b10, 16'h1234, 0, 2'b00, 16'h0000, 1,   0, 1, 0, 0, 0, 0, 2'b10, 16'h1234};
      vt[12] = '{0, 1, 2'b10, 16'h1234, 0, 2'b00, 16'h0000, 1,   0, 1, 0, 1, 0, 0, 2'b10, 16'h1234};
      vt[13] = '{0, 0, 2'b00, 16'h0000, 0, 2'b00, 16'h0000, 0,   0, 0, 0, 0, 0, 0, 2'b10, 16'h1234};

      idle_inputs();
      reset = 1;
      @(negedge clk);

      // ---- table ----
      for (int i = 0; i < 14; i++) begin
         reset = vt[i].rst; req_fcu = vt[i].rf; op_fcu = vt[i].opf; addr_fcu = vt[i].af;
         req_eu = vt[i].re; op_eu = vt[i].ope; addr_eu = vt[i].ae; ready_bus = vt[i].rdy;
         step();
         chk($sformatf("v%0d_cs", i), cs_biu, vt[i].cs);
         chk($sformatf("v%0d_gfcu", i), grant_fcu, vt[i].gf);
         chk($sformatf("v%0d_geu", i), grant_eu, vt[i].ge);
         chk($sformatf("v%0d_dfcu", i), done_fcu, vt[i].df);
         chk($sformatf("v%0d_deu", i), done_eu, vt[i].de);
         chk($sformatf("v%0d_err", i), timeout_err, vt[i].err);
         chk($sformatf("v%0d_sel", i), sel_biu, vt[i].sel);
         chk($sformatf("v%0d_addr", i), addr_biu, vt[i].addr);
      end

      // ---- starvation: both held, grant order EU x4 then FCU, repeating ----
      idle_inputs(); do_reset();
      req_fcu = 1; req_eu = 1; ready_bus = 1;
      for (int k = 0; k < 10; k++) exp_q.push_back(((k % 5) == 4) ? 1'b1 : 1'b0);
      for (int i = 0; i < 100 && got_q.size() < 10; i++) begin
         step();
         if (cs_biu) got_q.push_back(grant_fcu);
      end
      chk("starve_count", got_q.size(), 10);
      for (int k = 0; k < 10 && k < got_q.size(); k++)
         chk($sformatf("starve_order%0d", k), got_q[k], exp_q[k]);

      // ---- timeout: no ready, done after TIMEOUT wait cycles ----
      idle_inputs(); do_reset();
      req_eu = 1; addr_eu = 16'h0BAD;
      wait_cs("to_cs");
      begin
         int n = 0; logic seen = 0;
         while (n < 40 && !seen) begin step(); n++; seen = done_eu; end
         chk("to_seen", seen, 1);
         chk("to_latency", n, TIMEOUT + 1);
         chk("to_err", timeout_err, 1);
      end
      req_eu = 0; step();
      // a normal transaction afterwards
      req_eu = 1; ready_bus = 1;
      wait_cs("after_to_cs");
      step(); step();
      chk("after_to_done", done_eu, 1);
      chk("after_to_err", timeout_err, 0);
      req_eu = 0; ready_bus = 0; step();

      // ---- ready on the expiry cycle wins ----
      req_eu = 1;
      wait_cs("edge_cs");
      for (int j = 1; j <= TIMEOUT + 1; j++) begin
         ready_bus = (j == TIMEOUT + 1);
         step();
         if (j <= TIMEOUT) chk($sformatf("edge_nodone%0d", j), done_eu, 0);
      end
      chk("edge_done", done_eu, 1);
      chk("edge_err", timeout_err, 0);
      req_eu = 0; ready_bus = 0; step();

      // ---- reset during WAIT ----
      req_fcu = 1; addr_fcu = 16'h5555; op_fcu = 2'b10;
      wait_cs("rst_cs");
      step(); step();
      reset = 1; req_fcu = 0; step(); reset = 0;
      chk("rst_outputs", {cs_biu, grant_fcu, grant_eu, done_fcu, done_eu, timeout_err, sel_biu, addr_biu}, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("rst_nodone%0d", i), done_fcu | done_eu, 0);
      end
      req_fcu = 1; addr_fcu = 16'h0777; ready_bus = 1;
      step();
      chk("rst_fresh_cs", cs_biu, 1);
      chk("rst_fresh_addr", addr_biu, 16'h0777);
      step(); step(); req_fcu = 0; ready_bus = 0; step();

      // ---- randomized traffic ----
      begin
         int pct = 30;
         for (int c = 0; c < 3000; c++) begin
            if ((c % 200) == 0) begin
               case ($urandom_range(0, 3))
                  0: pct = 3;
                  1: pct = 20;
                  2: pct = 50;
                  default: pct = 90;
               endcase
            end
            reset = ($urandom_range(0, 299) == 0);
            if (req_fcu && e_df) req_fcu = 0;
            else if (!req_fcu && $urandom_range(0, 3) == 0) begin
               req_fcu = 1; op_fcu = 2'($urandom); addr_fcu = 16'($urandom);
            end
            if (req_eu && e_de) req_eu = 0;
            else if (!req_eu && $urandom_range(0, 2) == 0) begin
               req_eu = 1; op_eu = 2'($urandom); addr_eu = 16'($urandom);
            end
            if ($urandom_range(0, 19) == 0) addr_eu = 16'($urandom);
            if ($urandom_range(0, 19) == 0) req_fcu = ~req_fcu;
            ready_bus = ($urandom_range(0, 99) < pct);
            step();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
